switch_sweep_counter: RTL
=========================

Name: switch_sweep_counter

Overview:
- Upstream stage of the photonic-switch comparator.
- Generates the sweeping 7-bit count (drives comparator in_x), the active target (in_y) and the compare enable (en).
- Prescaler sets the sweep rate; runs continuous or one-shot sweeps.
- Target is double-buffered so host writes never disturb a sweep in progress.

Parameters:
- CNT_W, 7, width of count/target/period.
- PRESC_W, 8, width of prescale divider.

Ports:
- counter_clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a sweep.
- stop  in  1  one-cycle request to abort.
- one_shot  in  1  mode, sampled at start: 1 = single sweep, 0 = continuous.
- triangle  in  1  up/down sweep select, sampled at start; only honoured with TRIANGLE_SWEEP_EN.
- period  in  CNT_W  terminal count, sampled at start and at each wrap.
- prescale  in  PRESC_W  count advances every prescale+1 cycles, sampled at start.
- target_wr  in  1  write strobe for shadow target.
- target_in  in  CNT_W  shadow target data.
- count  out  CNT_W  sweep value, to comparator in_x.
- target  out  CNT_W  active target, to comparator in_y.
- cmp_en  out  1  comparator enable.
- wrap  out  1  one-cycle pulse on sweep completion.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (sync, counter_clk edge with reset=1):
  - count=0, target=0, shadow=0, cmp_en=0, wrap=0, busy=0.
  - Prescaler counter pcnt=0, state=IDLE.
  - Reset overrides every other input.
- States:
  - IDLE: count held at 0, cmp_en=0, busy=0.
  - RUN: cmp_en=1, busy=1.
- IDLE→RUN on start (cycle N). At N+1:
  - busy=1, cmp_en=1, count=0, pcnt=0.
  - period, prescale, one_shot latched.
  - target <= shadow, or <= target_in if target_wr is also high at N.
- Tick generation in RUN:
  - pcnt==presc_l: tick, pcnt<=0.
  - Otherwise pcnt<=pcnt+1.
  - First count=1 visible presc_l+1 cycles after entering RUN; prescale=0 gives a tick every cycle.
- Tick with count<period_l: count<=count+1.
- Tick with count==period_l (wrap):
  - Next cycle: count=0 and wrap=1 for exactly one cycle.
  - period_l re-sampled; target <= shadow (target_in bypass if target_wr in the same cycle).
  - one_shot=1: state <= IDLE and busy/cmp_en drop in the same cycle wrap is high.
  - one_shot=0: remain in RUN.
- period=0: count stays 0 and wrap pulses every tick. The comparator sees no count change and does not fire; this is documented, not corrected.
- stop in RUN → IDLE next cycle, with count=0, cmp_en=0, no wrap pulse.
- stop has priority over start and over a coincident wrap.
- stop in IDLE: no effect.
- start while in RUN: ignored; no restart.
- target_wr: shadow <= target_in in any state; the active target changes only at start or wrap.
- Reset asserted mid-sweep: immediate return to the reset values above; no wrap pulse.
- count never exceeds period_l. A period lowered mid-sweep takes effect only at the next wrap.

Optional Feature:
- Macro: TRIANGLE_SWEEP_EN.
- Defined, with triangle latched=1:
  - Count ramps 0→period_l, then period_l→0 (direction flips on the tick at period_l).
  - wrap pulses when count returns to 0.
  - period=0 behaves as the sawtooth case.
- Undefined: triangle port ignored (treated 0); sawtooth only; direction logic absent.

Decomposition:
- Package switch_ctrl_pkg:
  - State enum (IDLE, RUN).
  - Default CNT_W=7 and PRESC_W=8 constants.
  - Direction enum (UP, DOWN) under TRIANGLE_SWEEP_EN.
- Sub-module tick_prescaler:
  - Inputs: clear, enable, divider.
  - Output: one-cycle tick.
  - Instantiated once.

Test Plan:
- Reset, then start with period=5, prescale=0, one_shot=1 → count 0,1,2,3,4,5,0; one wrap pulse; busy low the cycle after count 5; cmp_en mirrors busy.
- prescale=3, period=2, continuous → each count value held 4 cycles; wrap every 12 cycles; runs until stop; stop → count=0, busy=0 next cycle, no wrap.
- target_wr target_in=20 mid-sweep (count=3, period=10) → target unchanged until wrap, then 20; target_wr coincident with wrap using 33 → target=33.
- stop and start asserted in the same IDLE cycle → stays IDLE; start during RUN → count sequence unaffected.
- reset asserted at count=4 → next cycle all outputs 0; later start works normally; period=0 → wrap every tick, count constant 0.
- With TRIANGLE_SWEEP_EN, triangle=1, period=3, prescale=0 → count 0,1,2,3,2,1,0; wrap when back at 0; without the macro the same stimulus gives a sawtooth.

Source files
------------

// File: rtl/switch_ctrl_pkg.sv
// Shared types and default widths for the photonic-switch sweep counter.
// The sweep direction type exists only when TRIANGLE_SWEEP_EN is defined.
package switch_ctrl_pkg;

  localparam int CNT_W_DEF   = 7;
  localparam int PRESC_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

`ifdef TRIANGLE_SWEEP_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;
`endif

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle ticks, one every divider_i+1 enabled cycles.
// clear_i holds the phase counter at zero so a new sweep always starts in phase.
module tick_prescaler #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] divider_i,
  output logic         tick_o
);

  localparam logic [W-1:0] PCNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] pcnt_q;
  logic [W-1:0] pcnt_d;
  logic         tick_s;

  assign tick_s = enable_i && !clear_i && (pcnt_q == divider_i);
  assign tick_o = tick_s;

  // Phase counter next state.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clear_i) begin
      pcnt_d = '0;
    end else if (!enable_i) begin
      pcnt_d = pcnt_q;
    end else if (tick_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/switch_sweep_counter.sv
// Sweep generator feeding the comparator: count (in_x), active target (in_y), enable.
// Define TRIANGLE_SWEEP_EN to add the up/down sweep; otherwise sawtooth only.
module switch_sweep_counter
  import switch_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               counter_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic               triangle,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               target_wr,
  input  logic [CNT_W-1:0]   target_in,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   target,
  output logic               cmp_en,
  output logic               wrap,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q,    state_d;
  logic [CNT_W-1:0]     count_q,    count_d;
  logic [CNT_W-1:0]     target_q,   target_d;
  logic [CNT_W-1:0]     shadow_q,   shadow_d;
  logic [CNT_W-1:0]     period_q,   period_d;
  logic [PRESC_W-1:0]   presc_q,    presc_d;
  logic                 one_shot_q, one_shot_d;
  logic                 wrap_q,     wrap_d;
  logic                 tick_s;
  logic [CNT_W-1:0]     shadow_sel_s;
  logic [CNT_W-1:0]     step_count_s;
  logic                 step_end_s;
`ifdef TRIANGLE_SWEEP_EN
  logic                 tri_q, tri_d;
  dir_e                 dir_q, dir_d;
  dir_e                 step_dir_s;
`else
  logic                 unused_triangle_s;
  assign unused_triangle_s = triangle;
`endif

  // A write in the same cycle as a target load bypasses the shadow register.
  assign shadow_sel_s = target_wr ? target_in : shadow_q;

  tick_prescaler #(.W(PRESC_W)) u_presc (
    .clk_i     (counter_clk),
    .reset_i   (reset),
    .clear_i   (state_q == ST_IDLE),
    .enable_i  (state_q == ST_RUN),
    .divider_i (presc_q),
    .tick_o    (tick_s)
  );

  // Value the count moves to on a tick, and whether that tick ends the sweep.
  always_comb begin
    step_count_s = count_q + CNT_ONE;
    step_end_s   = 1'b0;
`ifdef TRIANGLE_SWEEP_EN
    step_dir_s   = dir_q;
    if (tri_q && (period_q != '0)) begin
      if (dir_q == DIR_UP) begin
        if (count_q < period_q) begin
          step_count_s = count_q + CNT_ONE;
        end else if (period_q == CNT_ONE) begin
          step_end_s = 1'b1;
        end else begin
          step_count_s = count_q - CNT_ONE;
          step_dir_s   = DIR_DOWN;
        end
      end else begin
        if (count_q > CNT_ONE) begin
          step_count_s = count_q - CNT_ONE;
        end else begin
          step_end_s = 1'b1;
        end
      end
    end else begin
      if (count_q < period_q) begin
        step_count_s = count_q + CNT_ONE;
      end else begin
        step_end_s = 1'b1;
      end
    end
`else
    if (count_q < period_q) begin
      step_count_s = count_q + CNT_ONE;
    end else begin
      step_end_s = 1'b1;
    end
`endif
  end

  // Sweep control: state, count, latched configuration and target loading.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    shadow_d   = shadow_sel_s;
    period_d   = period_q;
    presc_d    = presc_q;
    one_shot_d = one_shot_q;
    wrap_d     = 1'b0;
`ifdef TRIANGLE_SWEEP_EN
    tri_d      = tri_q;
    dir_d      = dir_q;
`endif
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (start && !stop) begin
          state_d    = ST_RUN;
          period_d   = period;
          presc_d    = prescale;
          one_shot_d = one_shot;
          target_d   = shadow_sel_s;
`ifdef TRIANGLE_SWEEP_EN
          tri_d      = triangle;
          dir_d      = DIR_UP;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (tick_s && step_end_s) begin
          count_d  = '0;
          wrap_d   = 1'b1;
          period_d = period;
          target_d = shadow_sel_s;
`ifdef TRIANGLE_SWEEP_EN
          dir_d    = DIR_UP;
`endif
          state_d  = one_shot_q ? ST_IDLE : ST_RUN;
        end else if (tick_s) begin
          count_d = step_count_s;
`ifdef TRIANGLE_SWEEP_EN
          dir_d   = step_dir_s;
`endif
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge counter_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      target_q   <= '0;
      shadow_q   <= '0;
      period_q   <= '0;
      presc_q    <= '0;
      one_shot_q <= 1'b0;
      wrap_q     <= 1'b0;
`ifdef TRIANGLE_SWEEP_EN
      tri_q      <= 1'b0;
      dir_q      <= DIR_UP;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      target_q   <= target_d;
      shadow_q   <= shadow_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      one_shot_q <= one_shot_d;
      wrap_q     <= wrap_d;
`ifdef TRIANGLE_SWEEP_EN
      tri_q      <= tri_d;
      dir_q      <= dir_d;
`endif
    end
  end

  assign count  = count_q;
  assign target = target_q;
  assign wrap   = wrap_q;
  assign busy   = (state_q == ST_RUN);
  assign cmp_en = (state_q == ST_RUN);

endmodule
